// File: rtl/mem_str_fwd_ctrl.sv
// mem_str_fwd_ctrl
// ----------------
// Forwarding controller for the memory-stage store-data select mux.
//
// A two-deep history of register-file writes retiring through MEM/WB is kept:
// slot WB holds the write that just entered writeback (t), and slot TM1 holds
// the one before it (t-1). Each slot records a top and a bottom write port.
// The store sitting in EX/MEM has its two data-source registers compared
// against that history. For each operand the youngest matching copy is
// selected; if nothing matches, the EX/MEM register-read value is selected.
//
// Ports
//   clock           rising-edge system clock
//   reset_n         asynchronous active-low reset
//   pipe_adv        MEM->WB pipeline register advances (0 = stall, history holds)
//   pipe_flush      with pipe_adv, the entering MEM/WB slot is a bubble
//   wr_en_top_in    leaving instruction writes its top destination
//   wr_addr_top_in  top destination address
//   wr_en_bot_in    leaving instruction writes its bottom destination
//   wr_addr_bot_in  bottom destination address
//   str_valid       EX/MEM holds a store
//   str_src_bot     register supplying store data [7:0]
//   str_top_en      store also drives data [11:8]
//   str_src_top     register supplying store data [11:8]
//   sel_signal_bot  one-hot low-byte select:
//                   [0] ex_mem, [1] wb_top, [2] wb_bot, [3] tm1_top, [4] tm1_bot
//   sel_signal_top  one-hot high-nibble select, same encoding (all zero when
//                   str_top_en is low so the mux drives 0 on [11:8])
//   fwd_active      registered: a forward was issued in the previous cycle
//   wr_conflict     registered sticky: one instruction wrote both ports to the
//                   same register
module mem_str_fwd_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int ZERO_REG_FWD = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pipe_adv,
  input  logic              pipe_flush,
  input  logic              wr_en_top_in,
  input  logic [ADDR_W-1:0] wr_addr_top_in,
  input  logic              wr_en_bot_in,
  input  logic [ADDR_W-1:0] wr_addr_bot_in,
  input  logic              str_valid,
  input  logic [ADDR_W-1:0] str_src_bot,
  input  logic              str_top_en,
  input  logic [ADDR_W-1:0] str_src_top,
  output logic [4:0]        sel_signal_bot,
  output logic [4:0]        sel_signal_top,
  output logic              fwd_active,
  output logic              wr_conflict
);

  // One-hot select codes
  localparam logic [4:0] SEL_EXMEM   = 5'b00001;
  localparam logic [4:0] SEL_WB_TOP  = 5'b00010;
  localparam logic [4:0] SEL_WB_BOT  = 5'b00100;
  localparam logic [4:0] SEL_TM1_TOP = 5'b01000;
  localparam logic [4:0] SEL_TM1_BOT = 5'b10000;

  localparam logic ZERO_OK = (ZERO_REG_FWD != 0);

  // --------------------------------------------------------------------------
  // Write history
  // --------------------------------------------------------------------------
  logic              wb_vt_reg,  wb_vb_reg;
  logic [ADDR_W-1:0] wb_at_reg,  wb_ab_reg;
  logic              tm1_vt_reg, tm1_vb_reg;
  logic [ADDR_W-1:0] tm1_at_reg, tm1_ab_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_vt_reg  <= 1'b0;
      wb_vb_reg  <= 1'b0;
      wb_at_reg  <= '0;
      wb_ab_reg  <= '0;
      tm1_vt_reg <= 1'b0;
      tm1_vb_reg <= 1'b0;
      tm1_at_reg <= '0;
      tm1_ab_reg <= '0;
    end else if (pipe_adv) begin
      tm1_vt_reg <= wb_vt_reg;
      tm1_vb_reg <= wb_vb_reg;
      tm1_at_reg <= wb_at_reg;
      tm1_ab_reg <= wb_ab_reg;
      // A flushed slot still captures the addresses; only the valids drop.
      wb_vt_reg  <= wr_en_top_in & ~pipe_flush;
      wb_vb_reg  <= wr_en_bot_in & ~pipe_flush;
      wb_at_reg  <= wr_addr_top_in;
      wb_ab_reg  <= wr_addr_bot_in;
    end
  end

  // Register 0 is hardwired unless ZERO_REG_FWD is set. The qualification is
  // applied here at select time, so the raw history keeps whatever was written.
  logic wb_qvt, wb_qvb, tm1_qvt, tm1_qvb;

  assign wb_qvt  = wb_vt_reg  & (ZERO_OK | (wb_at_reg  != '0));
  assign wb_qvb  = wb_vb_reg  & (ZERO_OK | (wb_ab_reg  != '0));
  assign tm1_qvt = tm1_vt_reg & (ZERO_OK | (tm1_at_reg != '0));
  assign tm1_qvb = tm1_vb_reg & (ZERO_OK | (tm1_ab_reg != '0));

  // --------------------------------------------------------------------------
  // Per-operand source select: index 0 = bottom operand, 1 = top operand
  // --------------------------------------------------------------------------
  logic [1:0][ADDR_W-1:0] src_vec;
  logic [1:0][4:0]        sel_raw;

  assign src_vec[0] = str_src_bot;
  assign src_vec[1] = str_src_top;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      logic m_wb_bot, m_wb_top, m_tm1_bot, m_tm1_top;

      assign m_wb_bot  = wb_qvb  & (wb_ab_reg  == src_vec[gi]);
      assign m_wb_top  = wb_qvt  & (wb_at_reg  == src_vec[gi]);
      assign m_tm1_bot = tm1_qvb & (tm1_ab_reg == src_vec[gi]);
      assign m_tm1_top = tm1_qvt & (tm1_at_reg == src_vec[gi]);

      // Younger slot first; within a slot the bottom port wins, which also
      // resolves a same-address double write toward the bottom entry.
      assign sel_raw[gi] = m_wb_bot  ? SEL_WB_BOT  :
                           m_wb_top  ? SEL_WB_TOP  :
                           m_tm1_bot ? SEL_TM1_BOT :
                           m_tm1_top ? SEL_TM1_TOP :
                                       SEL_EXMEM;
    end
  endgenerate

  assign sel_signal_bot = str_valid ? sel_raw[0] : SEL_EXMEM;
  assign sel_signal_top = !str_top_en ? 5'b00000 :
                          str_valid   ? sel_raw[1] : SEL_EXMEM;

  // --------------------------------------------------------------------------
  // Status flags
  // --------------------------------------------------------------------------
  logic fwd_next;
  logic conflict_hit;

  assign fwd_next = str_valid &
                    ((sel_signal_bot != SEL_EXMEM) |
                     (str_top_en & (sel_signal_top != SEL_EXMEM)));

  assign conflict_hit = pipe_adv & ~pipe_flush & wr_en_top_in & wr_en_bot_in &
                        (wr_addr_top_in == wr_addr_bot_in);

  // fwd_active samples every clock, independent of stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fwd_active  <= 1'b0;
      wr_conflict <= 1'b0;
    end else begin
      fwd_active <= fwd_next;
      if (conflict_hit) begin
        wr_conflict <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_str_fwd_ctrl.sv
// Directed bench for mem_str_fwd_ctrl. Two instances share all stimulus:
// dut0 with ZERO_REG_FWD=0 and dut1 with ZERO_REG_FWD=1.
module tb_mem_str_fwd_ctrl;

  localparam int ADDR_W = 4;

  logic              clock;
  logic              reset_n;
  logic              pipe_adv;
  logic              pipe_flush;
  logic              wr_en_top_in;
  logic [ADDR_W-1:0] wr_addr_top_in;
  logic              wr_en_bot_in;
  logic [ADDR_W-1:0] wr_addr_bot_in;
  logic              str_valid;
  logic [ADDR_W-1:0] str_src_bot;
  logic              str_top_en;
  logic [ADDR_W-1:0] str_src_top;

  logic [4:0] sel_bot0, sel_top0, sel_bot1, sel_top1;
  logic       fwd0, fwd1, conf0, conf1;

  int n_vec;
  int n_miss;

  mem_str_fwd_ctrl #(.ADDR_W(ADDR_W), .ZERO_REG_FWD(0)) dut0 (
    .clock          (clock),
    .reset_n        (reset_n),
    .pipe_adv       (pipe_adv),
    .pipe_flush     (pipe_flush),
    .wr_en_top_in   (wr_en_top_in),
    .wr_addr_top_in (wr_addr_top_in),
    .wr_en_bot_in   (wr_en_bot_in),
    .wr_addr_bot_in (wr_addr_bot_in),
    .str_valid      (str_valid),
    .str_src_bot    (str_src_bot),
    .str_top_en     (str_top_en),
    .str_src_top    (str_src_top),
    .sel_signal_bot (sel_bot0),
    .sel_signal_top (sel_top0),
    .fwd_active     (fwd0),
    .wr_conflict    (conf0)
  );

  mem_str_fwd_ctrl #(.ADDR_W(ADDR_W), .ZERO_REG_FWD(1)) dut1 (
    .clock          (clock),
    .reset_n        (reset_n),
    .pipe_adv       (pipe_adv),
    .pipe_flush     (pipe_flush),
    .wr_en_top_in   (wr_en_top_in),
    .wr_addr_top_in (wr_addr_top_in),
    .wr_en_bot_in   (wr_en_bot_in),
    .wr_addr_bot_in (wr_addr_bot_in),
    .str_valid      (str_valid),
    .str_src_bot    (str_src_bot),
    .str_top_en     (str_top_en),
    .str_src_top    (str_src_top),
    .sel_signal_bot (sel_bot1),
    .sel_signal_top (sel_top1),
    .fwd_active     (fwd1),
    .wr_conflict    (conf1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end else begin
      $display("ok   %s: %b", tag, got);
    end
  endtask

  // Drive one capture cycle, then return to a quiet stalled pipe 1ns after the edge.
  task automatic cyc(input logic adv, input logic flush,
                     input logic en_t, input logic [ADDR_W-1:0] at,
                     input logic en_b, input logic [ADDR_W-1:0] ab);
    pipe_adv       = adv;
    pipe_flush     = flush;
    wr_en_top_in   = en_t;
    wr_addr_top_in = at;
    wr_en_bot_in   = en_b;
    wr_addr_bot_in = ab;
    @(posedge clock);
    #1;
    pipe_adv     = 1'b0;
    pipe_flush   = 1'b0;
    wr_en_top_in = 1'b0;
    wr_en_bot_in = 1'b0;
  endtask

  task automatic store(input logic v, input logic [ADDR_W-1:0] sb,
                       input logic ten, input logic [ADDR_W-1:0] st);
    str_valid   = v;
    str_src_bot = sb;
    str_top_en  = ten;
    str_src_top = st;
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset_n = 1'b0;
    pipe_adv = 1'b0; pipe_flush = 1'b0;
    wr_en_top_in = 1'b0; wr_addr_top_in = '0;
    wr_en_bot_in = 1'b0; wr_addr_bot_in = '0;
    store(1'b1, 4'd3, 1'b1, 4'd4);

    // Reset state
    #2;
    check_vec("rst_sel_bot", 32'(sel_bot0), 32'b00001);
    check_vec("rst_sel_top", 32'(sel_top0), 32'b00001);
    check_vec("rst_fwd",     32'(fwd0),     32'd0);
    check_vec("rst_conf",    32'(conf0),    32'd0);
    @(posedge clock); #1;
    @(posedge clock); #3;
    reset_n = 1'b1;
    store(1'b0, 4'd0, 1'b0, 4'd0);
    @(posedge clock); #1;

    // Bottom write to r3 ages through WB, TM1, then out
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd3);
    store(1'b1, 4'd3, 1'b0, 4'd0);
    check_vec("r3_wb_bot", 32'(sel_bot0), 32'b00100);
    check_vec("top_gated", 32'(sel_top0), 32'b00000);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    check_vec("r3_fwd",     32'(fwd0),     32'd1);
    check_vec("r3_tm1_bot", 32'(sel_bot0), 32'b10000);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    check_vec("r3_gone", 32'(sel_bot0), 32'b00001);
    store(1'b0, 4'd0, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    check_vec("fwd_idle", 32'(fwd0), 32'd0);

    // WB.top=5 and TM1.bot=5: younger wins
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5);
    cyc(1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0);
    store(1'b1, 4'd2, 1'b1, 4'd5);
    check_vec("r5_sel_top", 32'(sel_top0), 32'b00010);
    check_vec("r5_sel_bot", 32'(sel_bot0), 32'b00001);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    check_vec("r5_fwd", 32'(fwd0), 32'd1);
    store(1'b0, 4'd5, 1'b1, 4'd5);
    check_vec("nv_sel_top", 32'(sel_top0), 32'b00001);
    check_vec("nv_sel_bot", 32'(sel_bot0), 32'b00001);

    // Write to r0 via the top port
    store(1'b0, 4'd0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0);
    store(1'b1, 4'd0, 1'b0, 4'd0);
    check_vec("r0_nofwd", 32'(sel_bot0), 32'b00001);
    check_vec("r0_fwd",   32'(sel_bot1), 32'b00010);

    // Stall holds r7 in WB; flushed write is not captured
    store(1'b0, 4'd0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd7);
    store(1'b1, 4'd7, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 4'd7, 1'b1, 4'd7);
      check_vec($sformatf("stall%0d", i), 32'(sel_bot0), 32'b00100);
    end
    cyc(1'b1, 1'b1, 1'b1, 4'd7, 1'b1, 4'd7);
    check_vec("flush_r7", 32'(sel_bot0), 32'b10000);
    check_vec("flush_noconf", 32'(conf0), 32'd0);

    // Same-address double write -> sticky conflict, bottom wins
    store(1'b0, 4'd0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b1, 4'd9, 1'b1, 4'd9);
    check_vec("conf_set", 32'(conf0), 32'd1);
    store(1'b1, 4'd9, 1'b1, 4'd9);
    check_vec("conf_sel_bot", 32'(sel_bot0), 32'b00100);
    check_vec("conf_sel_top", 32'(sel_top0), 32'b00100);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    check_vec("conf_sticky", 32'(conf0), 32'd1);
    check_vec("conf_tm1_bot", 32'(sel_bot0), 32'b10000);

    // Asynchronous reset mid-cycle
    #2;
    reset_n = 1'b0;
    #1;
    check_vec("arst_conf",    32'(conf0),    32'd0);
    check_vec("arst_sel_bot", 32'(sel_bot0), 32'b00001);
    check_vec("arst_fwd",     32'(fwd0),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
